// File: rtl/uart_tx_mmio_if.sv
// Store/load bus between the core's memory stage and the memory-mapped UART.
// The master drives stores and load addresses; the slave returns read data and the window hit flag.
interface uart_tx_mmio_if;
  logic        write_mem;
  logic [2:0]  funct3;
  logic [31:0] write_address;
  logic [31:0] write_data;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        read_hit;

  modport master (output write_mem, funct3, write_address, write_data, read_address,
                  input  read_data, read_hit);
  modport slave  (input  write_mem, funct3, write_address, write_data, read_address,
                  output read_data, read_hit);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: a byte FIFO feeds an 8N1 serialiser, and the status register is readable on the load path.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
  parameter int          CLK_FREQ_HZ = 12000000,
  parameter int          BAUD        = 115200,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FFE0
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx
);
  localparam int DIVISOR = CLK_FREQ_HZ / BAUD;
  localparam int BW      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e          state_q;
  logic [BW-1:0]   baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
`ifdef UART_PARITY_EN
  logic            par_q;
`endif

  logic push_req, clr_ovf, full, empty, do_push, do_pop, baud_wrap;
  logic [7:0] cnt_ext;
  logic [7:0] status;
  logic       unused_bits;

  assign push_req  = bus.write_mem && (bus.write_address == BASE_ADDR) && (bus.funct3 <= 3'b010);
  assign clr_ovf   = bus.write_mem && (bus.write_address == STAT_ADDR);
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign do_push   = push_req && !full;
  assign do_pop    = (state_q == IDLE) && !empty;
  assign baud_wrap = (baud_q == BAUD_LAST);

  // Count field is 4 bits wide; a 16-deep full FIFO reads back as 0 there.
  assign cnt_ext       = 8'(count_q);
  assign status        = {cnt_ext[3:0], ovf_q, empty, full, state_q != IDLE};
  assign bus.read_hit  = (bus.read_address == BASE_ADDR) || (bus.read_address == STAT_ADDR);
  assign bus.read_data = (bus.read_address == STAT_ADDR) ? {24'd0, status} : 32'd0;
  assign unused_bits   = ^{bus.write_data[31:8], cnt_ext[7:4]};

  assign tx = tx_q;

  always_ff @(posedge clk)
    if (reset && do_push) mem_q[wptr_q] <= bus.write_data[7:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_req && full) ovf_q <= 1'b1;
      else if (clr_ovf)     ovf_q <= 1'b0;
    end
  end

  // tx is the registered image of the current state, so the line lags the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
`ifdef UART_PARITY_EN
      PARITY:  tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      tx_q <= tx_d;
      if (state_q != IDLE) baud_q <= baud_wrap ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: if (do_pop) begin
          shift_q <= mem_q[rptr_q];
          baud_q  <= '0;
          state_q <= START;
`ifdef UART_PARITY_EN
          par_q   <= ^mem_q[rptr_q];
`endif
        end
        START: if (baud_wrap) begin
          bit_idx_q <= '0;
          state_q   <= DATA;
        end
        DATA: if (baud_wrap) begin
          shift_q   <= shift_q >> 1;
          bit_idx_q <= bit_idx_q + 1'b1;
`ifdef UART_PARITY_EN
          if (bit_idx_q == 3'd7) state_q <= PARITY;
`else
          if (bit_idx_q == 3'd7) state_q <= STOP;
`endif
        end
        PARITY: if (baud_wrap) state_q <= STOP;
        STOP:   if (baud_wrap) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: decode/read table, directed frame sequences, and a randomized run
// checked against an edge-level schedule model of FIFO occupancy and frame timing.
module tb_uart_tx_mmio;
  localparam int          DIV   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'hFFFF_FFE0;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * DIV;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx;
  uart_tx_mmio_if bus();

  uart_tx_mmio #(.CLK_FREQ_HZ(4), .BAUD(1), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.write_mem = 1'b0;
    bus.funct3 = 3'd0;
    bus.write_address = 32'd0;
    bus.write_data = 32'd0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    bus.write_mem = 1'b1;
    bus.write_address = a;
    bus.write_data = d;
    bus.funct3 = f;
    step();
    bus.write_mem = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    bus.read_address = a;
    #1;
    d = bus.read_data;
    h = bus.read_hit;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    idle_bus();
    repeat (n) step();
    reset = 1'b1;
  endtask

  // Serial frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef UART_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic expect_frame(input logic [7:0] b, input string tag);
    for (int i = 0; i < NB; i++)
      for (int c = 0; c < DIV; c++) begin
        step();
        chk($sformatf("%s bit%0d cyc%0d", tag, i, c), 32'(tx), 32'(frame_bit(b, i)));
      end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic        hit;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[12];

  logic [31:0] rdv;
  logic        hv;

  // Randomized-phase model state
  int          push_t[$];
  int          pop_t[$];
  logic [7:0]  pop_b[$];
  int          last_pop;
  logic        m_ovf;

  initial begin
    tbl[0]  = '{1'b0, 32'd0,       3'd0, 32'd0,         BASE,        1'b1, 32'h0};
    tbl[1]  = '{1'b0, 32'd0,       3'd0, 32'd0,         BASE + 4,    1'b1, 32'h4};
    tbl[2]  = '{1'b0, 32'd0,       3'd0, 32'd0,         BASE + 8,    1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'd0,       3'd0, 32'd0,         BASE - 4,    1'b0, 32'h0};
    tbl[4]  = '{1'b0, 32'd0,       3'd0, 32'd0,         BASE + 2,    1'b0, 32'h0};
    tbl[5]  = '{1'b1, BASE,        3'd0, 32'h1234_56AB, BASE + 4,    1'b1, 32'h10};
    tbl[6]  = '{1'b1, BASE,        3'd1, 32'h1234_56AB, BASE + 4,    1'b1, 32'h10};
    tbl[7]  = '{1'b1, BASE,        3'd2, 32'h1234_56AB, BASE + 4,    1'b1, 32'h10};
    tbl[8]  = '{1'b1, BASE,        3'd3, 32'h1234_56AB, BASE + 4,    1'b1, 32'h4};
    tbl[9]  = '{1'b1, BASE,        3'd4, 32'h1234_56AB, BASE + 4,    1'b1, 32'h4};
    tbl[10] = '{1'b1, BASE + 4,    3'd2, 32'hFFFF_FFFF, BASE + 4,    1'b1, 32'h4};
    tbl[11] = '{1'b1, BASE + 8,    3'd2, 32'h0000_0077, BASE + 4,    1'b1, 32'h4};

    idle_bus();
    bus.read_address = BASE + 4;

    // Reset held with a live store to DATA: nothing may be queued.
    reset = 1'b0;
    bus.write_mem = 1'b1; bus.write_address = BASE; bus.funct3 = 3'd0; bus.write_data = 32'h55;
    repeat (3) step();
    chk("reset tx", 32'(tx), 32'd1);
    rd(BASE + 4, rdv, hv);
    chk("reset status", rdv, 32'h4);
    reset = 1'b1;
    bus.write_mem = 1'b0;
    step();
    rd(BASE + 4, rdv, hv);
    chk("post-reset no push", rdv, 32'h4);

    for (int k = 0; k < 12; k++) begin
      do_reset(2);
      if (tbl[k].wr) store(tbl[k].waddr, tbl[k].wdata, tbl[k].f3);
      rd(tbl[k].raddr, rdv, hv);
      chk($sformatf("vec%0d hit", k), 32'(hv), 32'(tbl[k].hit));
      chk($sformatf("vec%0d data", k), rdv, tbl[k].rdata);
    end

    // Single SW frame: pop one edge after the push, start bit the edge after that.
    do_reset(2);
    store(BASE, 32'h0000_0155, 3'b010);
    rd(BASE + 4, rdv, hv);
    chk("sw queued status", rdv, 32'h10);
    step();
    chk("sw pop-edge tx", 32'(tx), 32'd1);
    rd(BASE + 4, rdv, hv);
    chk("sw busy status", rdv, 32'h5);
    expect_frame(8'h55, "sw55");
    step();
    chk("sw after tx", 32'(tx), 32'd1);
    rd(BASE + 4, rdv, hv);
    chk("sw after status", rdv, 32'h4);

    // Ten back-to-back SB pushes: one popped, eight stored, one dropped.
    do_reset(2);
    for (int k = 0; k < 10; k++) store(BASE, 32'hA0 + 32'(k), 3'b000);
    rd(BASE + 4, rdv, hv);
    chk("overflow status", rdv, 32'h8B);
    store(BASE + 4, 32'hFFFF_FFFF, 3'b010);
    rd(BASE + 4, rdv, hv);
    chk("overflow cleared", rdv, 32'h83);

    // Two queued bytes: exactly one idle-high cycle between frames.
    do_reset(2);
    store(BASE, 32'hA5, 3'b000);
    store(BASE, 32'h3C, 3'b000);
    expect_frame(8'hA5, "pairA5");
    step();
    chk("idle gap", 32'(tx), 32'd1);
    expect_frame(8'h3C, "pair3C");

    // Reset in the middle of data bit 3 with two bytes still queued.
    do_reset(2);
    store(BASE, 32'h96, 3'b000);
    store(BASE, 32'h11, 3'b000);
    store(BASE, 32'h22, 3'b000);
    repeat (17) step();
    chk("mid bit3 tx", 32'(tx), 32'(frame_bit(8'h96, 4)));
    reset = 1'b0;
    step();
    chk("midreset tx", 32'(tx), 32'd1);
    rd(BASE + 4, rdv, hv);
    chk("midreset status", rdv, 32'h4);
    reset = 1'b1;
    begin
      int lows = 0;
      for (int c = 0; c < 2 * F + 4; c++) begin
        step();
        if (tx !== 1'b1) lows++;
      end
      chk("no frame after reset", 32'(lows), 32'd0);
    end

    // Parity-sensitive bytes (odd and even bit counts).
    do_reset(2);
    store(BASE, 32'h07, 3'b000);
    step();
    expect_frame(8'h07, "b07");
    do_reset(2);
    store(BASE, 32'h03, 3'b000);
    step();
    expect_frame(8'h03, "b03");

    // Randomized run against the schedule model.
    do_reset(2);
    last_pop = -1000;
    m_ovf = 1'b0;
    for (int t = 1; t <= 800; t++) begin
      int r, pre, cnt, busy;
      logic        wm, txe;
      logic [31:0] wa, wd, es;
      logic [2:0]  f;
      r = int'($urandom_range(0, 99));
      f = 3'($urandom_range(0, 7));
      wd = $urandom;
      wm = 1'b1;
      if (r < (((t % 200) < 100) ? 25 : 3)) wa = BASE;
      else if (r < 30) wa = BASE + 4;
      else if (r < 34) wa = BASE + 32'(8 * $urandom_range(1, 3));
      else begin wm = 1'b0; wa = BASE; end
      bus.write_mem = wm; bus.write_address = wa; bus.write_data = wd; bus.funct3 = f;

      pre = 0;
      foreach (push_t[i]) if (push_t[i] < t) pre++;
      foreach (pop_t[i])  if (pop_t[i] < t) pre--;
      if (wm && wa == BASE && f <= 3'd2) begin
        if (pre < DEPTH) begin
          int p;
          p = (t + 1 > last_pop + F + 1) ? t + 1 : last_pop + F + 1;
          push_t.push_back(t);
          pop_t.push_back(p);
          pop_b.push_back(wd[7:0]);
          last_pop = p;
        end else m_ovf = 1'b1;
      end
      if (wm && wa == BASE + 4) m_ovf = 1'b0;

      step();
      bus.write_mem = 1'b0;

      cnt = 0; busy = 0; txe = 1'b1;
      foreach (push_t[i]) if (push_t[i] <= t) cnt++;
      foreach (pop_t[i]) begin
        if (pop_t[i] <= t) cnt--;
        if (pop_t[i] <= t && t <= pop_t[i] + F - 1) busy = 1;
        if (pop_t[i] + 1 <= t && t <= pop_t[i] + F) txe = frame_bit(pop_b[i], (t - pop_t[i] - 1) / DIV);
      end
      es = (32'(cnt) << 4) | (32'(m_ovf) << 3) | ((cnt == 0) ? 32'h4 : 32'h0)
         | ((cnt == DEPTH) ? 32'h2 : 32'h0) | 32'(busy);
      rd(BASE + 4, rdv, hv);
      chk($sformatf("rand t%0d status", t), rdv, es);
      chk($sformatf("rand t%0d tx", t), 32'(tx), 32'(txe));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
